// File: rtl/ifetch_bus_bridge.sv
// ---------------------------------------------------------------------------
// ifetch_bus_bridge
//
// Instruction-fetch bridge between the core's ROM port and an external,
// variable-latency instruction bus with a req/ack handshake. A fetch that
// misses the one-entry buffer is forwarded to the bus while the core is
// stalled. The returned word is captured in the buffer and handed to the core
// on the following cycle. A fetch that sees no ack within TIMEOUT_CYC bus
// cycles is abandoned: a NOP (all zeros) is substituted and a sticky error
// flag is raised.
//
// Configuration macro:
//   IFB_HIT_BUF_EN  defined   : the buffered word persists and serves any
//                               later fetch of the same word until flush,
//                               reset or overwrite.
//                   undefined : the buffer is consumed by its first hit, so
//                               every fetch goes to the bus.
//
// Parameters:
//   TIMEOUT_CYC   BUSY/DRAIN cycles without ack before a fetch is abandoned
//                 (2..65535)
//
// Ports:
//   clk           core clock, rising edge
//   rst           asynchronous active-low reset
//   i_rom_ce      core fetch enable
//   i_pc          core fetch byte address (bits [1:0] ignored)
//   i_flush       invalidate buffer, discard any in-flight fetch
//   o_inst        instruction to the core (0 when not a hit)
//   o_stall       core must hold its PC this cycle
//   o_err         sticky bus-timeout flag, cleared only by reset
//   o_bus_req     registered bus request
//   o_bus_addr    registered bus word address
//   i_bus_ack     one-cycle data-valid strobe from the bus
//   i_bus_rdata   bus read data, valid with i_bus_ack
// ---------------------------------------------------------------------------
module ifetch_bus_bridge #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_rom_ce,
   input  logic [31:0] i_pc,
   input  logic        i_flush,
   output logic [31:0] o_inst,
   output logic        o_stall,
   output logic        o_err,
   output logic        o_bus_req,
   output logic [31:0] o_bus_addr,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // The counter holds the number of ack-less bus cycles already seen, so the
   // abandon fires in the cycle where that count equals TIMEOUT_CYC-1.
   localparam logic [15:0] LastCnt = 16'(TIMEOUT_CYC - 1);

   state_t      state_q, state_d;
   logic        bufValid_q, bufValid_d;
   logic [29:0] bufTag_q, bufTag_d;
   logic [31:0] bufData_q, bufData_d;
   logic [15:0] timeoutCnt_q, timeoutCnt_d;
   logic        err_q, err_d;
   logic        busReq_q, busReq_d;
   logic [31:0] busAddr_q, busAddr_d;

   logic        hit;
   logic        timeoutNow;
   logic        unusedPcBits;

   // The buffer is tagged by word address, so byte-offset bits play no part.
   assign hit          = bufValid_q && (bufTag_q == i_pc[31:2]);
   assign timeoutNow   = !i_bus_ack && (timeoutCnt_q == LastCnt);
   assign unusedPcBits = ^i_pc[1:0];

   // State register: every piece of bridge state lives here and is cleared
   // asynchronously, which also drops an outstanding request immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         bufValid_q   <= 1'b0;
         bufTag_q     <= '0;
         bufData_q    <= '0;
         timeoutCnt_q <= '0;
         err_q        <= 1'b0;
         busReq_q     <= 1'b0;
         busAddr_q    <= '0;
      end else begin
         state_q      <= state_d;
         bufValid_q   <= bufValid_d;
         bufTag_q     <= bufTag_d;
         bufData_q    <= bufData_d;
         timeoutCnt_q <= timeoutCnt_d;
         err_q        <= err_d;
         busReq_q     <= busReq_d;
         busAddr_q    <= busAddr_d;
      end
   end

   // Next-state logic. A miss launches a bus fetch; the fetch then runs to
   // completion (ack or timeout) regardless of what the core does with its
   // PC or enable. A flush while the fetch is outstanding parks the FSM in
   // DRAIN so the bus handshake still completes but the data is dropped.
   // The flush override sits after the case so that it beats any buffer
   // write made in the same cycle.
   always_comb begin
      state_d      = state_q;
      bufValid_d   = bufValid_q;
      bufTag_d     = bufTag_q;
      bufData_d    = bufData_q;
      timeoutCnt_d = timeoutCnt_q;
      err_d        = err_q;
      busReq_d     = busReq_q;
      busAddr_d    = busAddr_q;

`ifndef IFB_HIT_BUF_EN
      // Single-use buffer: the word is consumed by the cycle that reads it.
      if (i_rom_ce && hit) begin
         bufValid_d = 1'b0;
      end
`endif

      case (state_q)
         IDLE: begin
            if (i_rom_ce && !hit && !i_flush) begin
               state_d      = BUSY;
               busReq_d     = 1'b1;
               busAddr_d    = {i_pc[31:2], 2'b00};
               timeoutCnt_d = '0;
            end
         end
         BUSY: begin
            if (i_bus_ack || timeoutNow) begin
               state_d  = IDLE;
               busReq_d = 1'b0;
               if (!i_flush) begin
                  bufValid_d = 1'b1;
                  bufTag_d   = busAddr_q[31:2];
                  bufData_d  = i_bus_ack ? i_bus_rdata : 32'h0;
               end
               if (timeoutNow) begin
                  err_d = 1'b1;
               end
            end else begin
               timeoutCnt_d = timeoutCnt_q + 16'd1;
               if (i_flush) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (i_bus_ack || timeoutNow) begin
               state_d  = IDLE;
               busReq_d = 1'b0;
               if (timeoutNow) begin
                  err_d = 1'b1;
               end
            end else begin
               timeoutCnt_d = timeoutCnt_q + 16'd1;
            end
         end
         default: begin
            state_d  = IDLE;
            busReq_d = 1'b0;
         end
      endcase

      if (i_flush) begin
         bufValid_d = 1'b0;
      end
   end

   // Output logic. The stall is qualified with reset so the core sees a
   // clean, unstalled port while the bridge is held in reset; o_inst needs
   // no such qualification because the buffer is already invalid then.
   always_comb begin
      o_inst     = (i_rom_ce && hit) ? bufData_q : 32'h0;
      o_stall    = rst && i_rom_ce && !hit && !i_flush;
      o_err      = err_q;
      o_bus_req  = busReq_q;
      o_bus_addr = busAddr_q;
   end

endmodule

// File: tb/tb_ifetch_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_ifetch_bus_bridge
//
// Scoreboard bench for ifetch_bus_bridge. The stimulus process plans each
// fetch (PC, bus latency, returned word), works out the expected result from
// a transaction-level model of the one-entry buffer and pushes it into a
// queue. A monitor process pops and compares whenever the core port shows a
// delivered instruction, and checks every bus request against its own queue.
// A bus responder acks after the planned number of request cycles.
// ---------------------------------------------------------------------------
module tb_ifetch_bus_bridge;

   localparam int unsigned TO = 4;
`ifdef IFB_HIT_BUF_EN
   localparam bit HitBuf = 1'b1;
`else
   localparam bit HitBuf = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        i_rom_ce;
   logic [31:0] i_pc;
   logic        i_flush;
   logic [31:0] o_inst;
   logic        o_stall;
   logic        o_err;
   logic        o_bus_req;
   logic [31:0] o_bus_addr;
   logic        i_bus_ack;
   logic [31:0] i_bus_rdata;

   always #5 clk = ~clk;

   ifetch_bus_bridge #(.TIMEOUT_CYC(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_rom_ce   (i_rom_ce),
      .i_pc       (i_pc),
      .i_flush    (i_flush),
      .o_inst     (o_inst),
      .o_stall    (o_stall),
      .o_err      (o_err),
      .o_bus_req  (o_bus_req),
      .o_bus_addr (o_bus_addr),
      .i_bus_ack  (i_bus_ack),
      .i_bus_rdata(i_bus_rdata)
   );

   typedef struct {
      logic [31:0] inst;
      int          stall;
      logic        err;
   } fetchExp_t;

   typedef struct {
      logic [31:0] addr;
      int          reqCycles;
   } busExp_t;

   fetchExp_t   fetchQ[$];
   busExp_t     busQ[$];
   int          compared   = 0;
   int          mismatched = 0;

   // Bus plan for the fetch in progress: ack on the plannedK-th request
   // cycle (0 = never ack) with plannedData.
   int          plannedK    = 0;
   logic [31:0] plannedData = 32'h0;

   // Transaction-level model of the buffer and the sticky error flag.
   logic        mValid = 1'b0;
   logic [29:0] mTag   = '0;
   logic [31:0] mData  = '0;
   logic        mErr   = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic finishRun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   endtask

   task automatic waitNoStall();
      bit done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (!o_stall) done = 1'b1;
      end
      if (!done) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL stall_bound: stall still high after 64 cycles, expected release");
         finishRun();
      end
   endtask

   // One core fetch: plan the bus, predict the outcome, then hold the PC
   // until the bridge releases the stall.
   task automatic applyStimulus(input logic [31:0] pc, input int k,
                                input logic [31:0] data);
      fetchExp_t fe;
      busExp_t   be;
      bit        ok;
      int        c;
      @(posedge clk);
      #1;
      plannedK    = k;
      plannedData = data;
      if (HitBuf && mValid && mTag == pc[31:2]) begin
         fe.inst  = mData;
         fe.stall = 0;
         fe.err   = mErr;
      end else begin
         ok = (k != 0) && (k <= int'(TO));
         c  = ok ? k : int'(TO);
         fe.inst = ok ? data : 32'h0;
         if (!ok) mErr = 1'b1;
         mValid   = 1'b1;
         mTag     = pc[31:2];
         mData    = fe.inst;
         fe.stall = c + 1;
         fe.err   = mErr;
         be.addr      = {pc[31:2], 2'b00};
         be.reqCycles = c;
         busQ.push_back(be);
      end
      fetchQ.push_back(fe);
      i_pc     = pc;
      i_rom_ce = 1'b1;
      waitNoStall();
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         i_rom_ce = 1'b0;
      end
   endtask

   task automatic waitReqLow();
      bit done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (!o_bus_req) done = 1'b1;
      end
      if (!done) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL req_bound: bus_req still high after 64 cycles, expected low");
         finishRun();
      end
   endtask

   // Bus responder: counts request cycles and acks on the planned one.
   initial begin
      int cnt = 0;
      i_bus_ack   = 1'b0;
      i_bus_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (o_bus_req && rst) begin
            cnt++;
            if (plannedK != 0 && cnt == plannedK) begin
               i_bus_ack   = 1'b1;
               i_bus_rdata = plannedData;
            end else begin
               i_bus_ack   = 1'b0;
               i_bus_rdata = $urandom;
            end
         end else begin
            cnt         = 0;
            i_bus_ack   = 1'b0;
            i_bus_rdata = $urandom;
         end
      end
   end

   // Monitor: delivered instructions against the fetch queue, bus requests
   // against the bus queue.
   initial begin
      int        stallCnt = 0;
      int        reqCnt   = 0;
      bit        prevReq  = 1'b0;
      busExp_t   curBus;
      fetchExp_t fe;
      curBus.addr      = '0;
      curBus.reqCycles = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stallCnt = 0;
            reqCnt   = 0;
            prevReq  = 1'b0;
         end else begin
            if (i_rom_ce && o_stall) begin
               stallCnt++;
            end else if (i_rom_ce) begin
               if (fetchQ.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("[TB] FAIL unexpected_inst: got %h, expected no delivery", o_inst);
               end else begin
                  fe = fetchQ.pop_front();
                  checkOutput("inst", o_inst, fe.inst);
                  checkOutput("stall_cycles", stallCnt, fe.stall);
                  checkOutput("err", {31'd0, o_err}, {31'd0, fe.err});
               end
               stallCnt = 0;
            end else begin
               stallCnt = 0;
            end

            if (o_bus_req) begin
               if (!prevReq) begin
                  if (busQ.size() == 0) begin
                     compared++;
                     mismatched++;
                     $display("[TB] FAIL unexpected_req: got request to %h, expected none", o_bus_addr);
                     curBus.addr      = o_bus_addr;
                     curBus.reqCycles = 0;
                  end else begin
                     curBus = busQ.pop_front();
                  end
                  reqCnt = 0;
               end
               reqCnt++;
               checkOutput("bus_addr", o_bus_addr, curBus.addr);
            end else if (prevReq && curBus.reqCycles != 0) begin
               checkOutput("req_cycles", reqCnt, curBus.reqCycles);
            end
            prevReq = o_bus_req;
         end
      end
   end

   // Main stimulus sequence.
   initial begin
      logic [31:0] pcList [4];
      logic [31:0] pc;
      pcList[0] = 32'h0000_1000;
      pcList[1] = 32'h0000_1004;
      pcList[2] = 32'h0000_1008;
      pcList[3] = 32'h0000_2000;

      rst      = 1'b0;
      i_rom_ce = 1'b1;
      i_pc     = 32'h0000_0100;
      i_flush  = 1'b0;

      // Reset values, with the core already requesting a fetch.
      @(negedge clk);
      checkOutput("rst_inst", o_inst, 32'h0);
      checkOutput("rst_stall", {31'd0, o_stall}, 32'h0);
      checkOutput("rst_err", {31'd0, o_err}, 32'h0);
      checkOutput("rst_req", {31'd0, o_bus_req}, 32'h0);
      checkOutput("rst_addr", o_bus_addr, 32'h0);
      @(negedge clk);
      rst      = 1'b1;
      i_rom_ce = 1'b0;
      idleCycles(2);

      // Basic miss with 3-cycle ack, then a refetch of the same PC.
      applyStimulus(32'h0000_0100, 3, 32'h3C01_0001);
      applyStimulus(32'h0000_0100, 2, 32'h1111_2222);
      idleCycles(1);

      // Ack arrives in exactly the cycle the timeout would fire.
      applyStimulus(32'h0000_0200, int'(TO), 32'hA5A5_5A5A);
      idleCycles(1);

      // Flush during BUSY; the in-flight word must be discarded.
      @(posedge clk);
      #1;
      plannedK    = 3;
      plannedData = 32'hDEAD_BEEF;
      busQ.push_back('{32'h0000_0300, 3});
      i_pc     = 32'h0000_0302;
      i_rom_ce = 1'b1;
      @(posedge clk);
      #1;
      i_flush  = 1'b1;
      i_rom_ce = 1'b0;
      @(posedge clk);
      #1;
      i_flush = 1'b0;
      mValid  = 1'b0;
      waitReqLow();
      checkOutput("drain_req", {31'd0, o_bus_req}, 32'h0);
      applyStimulus(32'h0000_0300, 2, 32'h0BAD_F00D);
      idleCycles(1);

      // Timeout: no ack at all, NOP delivered and error becomes sticky.
      applyStimulus(32'h0000_0400, 0, 32'h0);
      applyStimulus(32'h0000_0400, 1, 32'h7777_0001);
      idleCycles(1);

      // Randomized fetch stream over a small set of words.
      for (int n = 0; n < 150; n++) begin
         pc = pcList[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
         applyStimulus(pc, $urandom_range(1, TO + 1), $urandom);
         if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
      end
      idleCycles(1);

      // Reset while a fetch is outstanding.
      @(posedge clk);
      #1;
      plannedK = 0;
      busQ.push_back('{32'h0000_0500, 0});
      i_pc     = 32'h0000_0500;
      i_rom_ce = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("midrst_inst", o_inst, 32'h0);
      checkOutput("midrst_stall", {31'd0, o_stall}, 32'h0);
      checkOutput("midrst_err", {31'd0, o_err}, 32'h0);
      checkOutput("midrst_req", {31'd0, o_bus_req}, 32'h0);
      checkOutput("midrst_addr", o_bus_addr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b1;
      i_rom_ce = 1'b0;
      mValid   = 1'b0;
      mErr     = 1'b0;
      applyStimulus(32'h0000_0500, 2, 32'h2468_ACE0);
      idleCycles(3);

      checkOutput("fetch_queue_left", fetchQ.size(), 32'd0);
      checkOutput("bus_queue_left", busQ.size(), 32'd0);
      finishRun();
   end

endmodule
